// File: rtl/sync_fifo_gen_if.sv
// Bus bundle for sync_fifo_gen. The producer/consumer side uses master and the FIFO uses slave.
// A write request is taken on a rising clk edge only when wr_en=1 and fifo_full=0. A read request is taken only when rd_en=1 and fifo_empty=0.
interface sync_fifo_gen_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   af_thresh;
  logic [ADDR_WIDTH:0]   ae_thresh;
  logic [ADDR_WIDTH:0]   fifo_counter;
  logic                  overflow;
  logic                  underflow;
  logic                  clr_err;

  modport master (
    output wr_en, data_in, rd_en, af_thresh, ae_thresh, clr_err,
    input  data_out, data_valid, fifo_full, fifo_empty, almost_full,
           almost_empty, fifo_counter, overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en, af_thresh, ae_thresh, clr_err,
    output data_out, data_valid, fifo_full, fifo_empty, almost_full,
           almost_empty, fifo_counter, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO with thresholds, sticky error flags and a standard or FWFT read port.
module sync_fifo_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0
) (
  input logic            clk,
  input logic            rst,
  sync_fifo_gen_if.slave bus
);
  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty, wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;

  // Accepts are based only on registered occupancy, so no input reaches the flags combinationally.
  assign full   = (count_q == DEPTH_CNT);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
    // Clear first so that a set event in the same cycle overrides it.
    if (bus.clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (bus.wr_en & full)  overflow_d  = 1'b1;
    if (bus.rd_en & empty) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left unreset; it is never observed while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown directly; it is forced to zero while empty to keep stale contents hidden.
      always_comb begin
        rd_data = '0;
        if (!empty) rd_data = mem_q[rd_ptr_q];
      end
      assign rd_valid = ~empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q, dout_d;
      logic                  dvalid_q, dvalid_d;

      always_comb begin
        dout_d   = dout_q;
        dvalid_d = rd_acc;
        if (rd_acc) dout_d = mem_q[rd_ptr_q];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dout_q   <= '0;
          dvalid_q <= 1'b0;
        end else begin
          dout_q   <= dout_d;
          dvalid_q <= dvalid_d;
        end
      end

      assign rd_data  = dout_q;
      assign rd_valid = dvalid_q;
    end
  endgenerate

  assign bus.data_out     = rd_data;
  assign bus.data_valid   = rd_valid;
  assign bus.fifo_full    = full;
  assign bus.fifo_empty   = empty;
  assign bus.almost_full  = (count_q >= bus.af_thresh);
  assign bus.almost_empty = (count_q <= bus.ae_thresh);
  assign bus.fifo_counter = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

  a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= DEPTH_CNT);
  a_ptr_count:   assert property (@(posedge clk) disable iff (rst)
                   (wr_ptr_q - rd_ptr_q) == count_q[ADDR_WIDTH-1:0]);
endmodule
